// File: rtl/conv_phase_sequencer_pkg.sv
// Shared definitions for the convolution phase sequencer.
//  - State encoding constants. LOAD_W..DRAIN are deliberately consecutive
//    (1..4) so the enable decode can index them with a loop.
//  - Default group sizes and a helper that derives the phase counter width
//    from the largest group size.
package conv_phase_sequencer_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_LOAD_I = 3'd2;
    localparam logic [2:0] ST_ACCUM  = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int NUM_EN_PHASES = 4;

    localparam int DEF_W_GROUP    = 4;
    localparam int DEF_O_GROUP    = 4;
    localparam int DEF_BLOCK_CNT  = 4;

    // The counter runs 0..size-1, so it needs clog2(largest size) bits
    // (at least one).
    function automatic int phase_cnt_width(input int w, input int i, input int o);
        int m;
        m = w;
        if (i > m) m = i;
        if (o > m) m = o;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/conv_phase_sequencer_if.sv
// Control bundle between the top-level controller and the phase sequencer.
//  master : controller side, drives start/stall, observes status/enables
//  slave  : sequencer side
//  start, stall             : pass request and global freeze
//  busy, done               : pass status (done is a one-cycle pulse)
//  EN_W, EN_I, EN_O_In,
//  EN_O_Out                 : address-advance enables toward PE_Controller
//  block_idx                : block currently being processed
interface conv_phase_sequencer_if #(
    parameter int BlockCountWidth = 2
);
    logic                       start;
    logic                       stall;
    logic                       busy;
    logic                       done;
    logic                       EN_W;
    logic                       EN_I;
    logic                       EN_O_In;
    logic                       EN_O_Out;
    logic [BlockCountWidth-1:0] block_idx;

    modport master (
        output start, stall,
        input  busy, done, EN_W, EN_I, EN_O_In, EN_O_Out, block_idx
    );

    modport slave (
        input  start, stall,
        output busy, done, EN_W, EN_I, EN_O_In, EN_O_Out, block_idx
    );
endinterface

// File: rtl/conv_phase_sequencer_phase_counter.sv
// Phase length counter shared by every timed phase of the sequencer.
//  clk   : clock
//  sclr  : synchronous reset, active-high
//  clr   : synchronous clear
//  en    : count enable (only unstalled cycles of a timed phase)
//  limit : terminal count value (phase length - 1), chosen per state
//  tc    : high while the count equals limit; an enabled tc cycle wraps to 0
module conv_phase_sequencer_phase_counter #(
    parameter int CntWidth = 3
) (
    input  logic                clk,
    input  logic                sclr,
    input  logic                clr,
    input  logic                en,
    input  logic [CntWidth-1:0] limit,
    output logic                tc
);
    logic [CntWidth-1:0] count_reg;

    assign tc = (count_reg == limit);

    always_ff @(posedge clk) begin
        if (sclr || clr) begin
            count_reg <= '0;
        end else if (en) begin
            // Wrapping at terminal count leaves the counter at 0 for the
            // next phase, so the FSM never has to clear it explicitly.
            count_reg <= tc ? '0 : count_reg + CntWidth'(1);
        end
    end
endmodule

// File: rtl/conv_phase_sequencer.sv
// Convolution phase sequencer: orders the PE_Controller enables for one pass.
// A pass is LOAD_W once, then BlockCount blocks of LOAD_I / ACCUM / DRAIN,
// then a single DONE cycle. stall freezes all state and masks the enables.
//  clk  : clock, rising edge
//  sclr : synchronous reset, active-high, has priority over everything
//  seq  : control bundle (slave side), see conv_phase_sequencer_if
module conv_phase_sequencer
    import conv_phase_sequencer_pkg::*;
#(
    parameter int W_PEGroupSize   = DEF_W_GROUP,
    parameter int O_PEGroupSize   = DEF_O_GROUP,
    parameter int I_PEGroupSize   = W_PEGroupSize + O_PEGroupSize - 1,
    parameter int BlockCount      = DEF_BLOCK_CNT,
    parameter int BlockCountWidth = 2,
    parameter int PhaseCntWidth   = phase_cnt_width(W_PEGroupSize, I_PEGroupSize, O_PEGroupSize)
) (
    input  logic                   clk,
    input  logic                   sclr,
    conv_phase_sequencer_if.slave  seq
);
    localparam logic [BlockCountWidth-1:0] LAST_BLOCK = BlockCountWidth'(BlockCount - 1);

    logic [2:0]                 state_reg, state_next;
    logic [BlockCountWidth-1:0] block_idx_reg, block_idx_next;
    logic [PhaseCntWidth-1:0]   limit;
    logic                       cnt_en;
    logic                       tc;
    logic [NUM_EN_PHASES-1:0]   en_vec;

    // Only the four timed phases consume counter cycles, and only unstalled.
    assign cnt_en = ~seq.stall &&
                    (state_reg >= ST_LOAD_W) && (state_reg <= ST_DRAIN);

    always_comb begin
        limit = '0;
        case (state_reg)
            ST_LOAD_W: limit = PhaseCntWidth'(W_PEGroupSize - 1);
            ST_LOAD_I: limit = PhaseCntWidth'(I_PEGroupSize - 1);
            ST_ACCUM:  limit = PhaseCntWidth'(O_PEGroupSize - 1);
            ST_DRAIN:  limit = PhaseCntWidth'(O_PEGroupSize - 1);
            default:   limit = '0;
        endcase
    end

    conv_phase_sequencer_phase_counter #(
        .CntWidth (PhaseCntWidth)
    ) u_phase_counter (
        .clk   (clk),
        .sclr  (sclr),
        .clr   (state_reg == ST_IDLE),
        .en    (cnt_en),
        .limit (limit),
        .tc    (tc)
    );

    always_comb begin
        state_next     = state_reg;
        block_idx_next = block_idx_reg;
        if (!seq.stall) begin
            case (state_reg)
                ST_IDLE: begin
                    if (seq.start) state_next = ST_LOAD_W;
                end
                ST_LOAD_W: begin
                    if (tc) state_next = ST_LOAD_I;
                end
                ST_LOAD_I: begin
                    if (tc) state_next = ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (tc) state_next = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (tc) begin
                        if (block_idx_reg == LAST_BLOCK) begin
                            // block_idx stays on the last block through DONE.
                            state_next = ST_DONE;
                        end else begin
                            // Weights remain resident: next block skips LOAD_W.
                            block_idx_next = block_idx_reg + BlockCountWidth'(1);
                            state_next     = ST_LOAD_I;
                        end
                    end
                end
                ST_DONE: begin
                    state_next     = ST_IDLE;
                    block_idx_next = '0;
                end
                default: begin
                    state_next     = ST_IDLE;
                    block_idx_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_reg     <= ST_IDLE;
            block_idx_reg <= '0;
        end else begin
            state_reg     <= state_next;
            block_idx_reg <= block_idx_next;
        end
    end

    // en_vec[0..3] = EN_W, EN_I, EN_O_In, EN_O_Out; relies on LOAD_W..DRAIN
    // being encoded consecutively.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_EN_PHASES; gi++) begin : g_en
            assign en_vec[gi] = (state_reg == 3'(ST_LOAD_W + gi)) && !seq.stall;
        end
    endgenerate

    assign seq.EN_W      = en_vec[0];
    assign seq.EN_I      = en_vec[1];
    assign seq.EN_O_In   = en_vec[2];
    assign seq.EN_O_Out  = en_vec[3];
    assign seq.busy      = (state_reg != ST_IDLE);
    assign seq.done      = (state_reg == ST_DONE) && !seq.stall;
    assign seq.block_idx = block_idx_reg;
endmodule

// File: tb/tb_conv_phase_sequencer.sv
// Bench for conv_phase_sequencer. The reference model is a queue holding the
// remaining per-cycle schedule of a pass (one entry per enable cycle plus the
// done cycle); every unstalled cycle consumes one entry.
module tb_conv_phase_sequencer;
    localparam int W  = 4;
    localparam int O  = 4;
    localparam int I  = W + O - 1;
    localparam int NB = 4;

    // Phase tags of the model schedule.
    localparam int PH_W    = 0;
    localparam int PH_I    = 1;
    localparam int PH_OIN  = 2;
    localparam int PH_OOUT = 3;
    localparam int PH_DONE = 4;

    logic clk = 1'b0;
    logic sclr;
    always #5 clk = ~clk;

    conv_phase_sequencer_if #(.BlockCountWidth(2)) bus ();

    conv_phase_sequencer dut (
        .clk  (clk),
        .sclr (sclr),
        .seq  (bus)
    );

    typedef struct {
        int ph;
        int blk;
    } ent_t;

    ent_t sched[$];
    int   done_cycles[$];
    int   cyc;
    int   tests = 0;
    int   fails = 0;
    int   n_w, n_i, n_oi, n_oo, n_i_blk0;
    logic busy66;
    logic [1:0] blk_at20;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void fill_sched();
        ent_t e;
        for (int k = 0; k < W; k++) begin e.ph = PH_W; e.blk = 0; sched.push_back(e); end
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < I; k++) begin e.ph = PH_I;    e.blk = b; sched.push_back(e); end
            for (int k = 0; k < O; k++) begin e.ph = PH_OIN;  e.blk = b; sched.push_back(e); end
            for (int k = 0; k < O; k++) begin e.ph = PH_OOUT; e.blk = b; sched.push_back(e); end
        end
        e.ph = PH_DONE; e.blk = NB - 1; sched.push_back(e);
    endfunction

    // {busy, done, EN_W, EN_I, EN_O_In, EN_O_Out, block_idx[1:0]}
    function automatic logic [7:0] expected_vec();
        ent_t h;
        logic act;
        if (sched.size() == 0) return 8'h00;
        h   = sched[0];
        act = !bus.stall;
        return {1'b1, act && h.ph == PH_DONE, act && h.ph == PH_W, act && h.ph == PH_I,
                act && h.ph == PH_OIN, act && h.ph == PH_OOUT, 2'(h.blk)};
    endfunction

    function automatic void clear_stats();
        n_w = 0; n_i = 0; n_oi = 0; n_oo = 0; n_i_blk0 = 0;
        busy66 = 1'bx; blk_at20 = 2'bxx;
        done_cycles.delete();
    endfunction

    // One clock cycle: compare at the falling edge, advance the model on the
    // rising edge with the inputs the DUT sampled there.
    task automatic cycle();
        logic [7:0] obs;
        @(negedge clk);
        obs = {bus.busy, bus.done, bus.EN_W, bus.EN_I, bus.EN_O_In, bus.EN_O_Out, bus.block_idx};
        chk($sformatf("outputs@cycle%0d", cyc), 32'(obs), 32'(expected_vec()));
        if (bus.EN_W === 1'b1)     n_w++;
        if (bus.EN_I === 1'b1)     n_i++;
        if (bus.EN_O_In === 1'b1)  n_oi++;
        if (bus.EN_O_Out === 1'b1) n_oo++;
        if (bus.EN_I === 1'b1 && bus.block_idx === 2'd0) n_i_blk0++;
        if (bus.done === 1'b1) done_cycles.push_back(cyc);
        if (cyc == 66) busy66 = bus.busy;
        if (cyc == 20) blk_at20 = bus.block_idx;
        @(posedge clk);
        if (sclr) sched.delete();
        else if (bus.stall) begin end
        else if (sched.size() == 0) begin if (bus.start) fill_sched(); end
        else void'(sched.pop_front());
        cyc++;
        #1;
    endtask

    task automatic reset_dut();
        sclr = 1'b1; bus.start = 1'b0; bus.stall = 1'b0;
        cycle();
        cycle();
        sclr = 1'b0;
        cyc = 0;
        clear_stats();
    endtask

    function automatic int first_done();
        return (done_cycles.size() > 0) ? done_cycles[0] : -1;
    endfunction

    initial begin
        sclr = 1'b1; bus.start = 1'b0; bus.stall = 1'b0; cyc = -10;
        repeat (2) @(posedge clk);
        #1;
        sched.delete();

        // Scenario 1: single clean pass.
        reset_dut();
        for (int c = 0; c < 72; c++) begin
            bus.start = (cyc == 0); bus.stall = 1'b0;
            cycle();
        end
        chk("s1_done_count", 32'(done_cycles.size()), 32'd1);
        chk("s1_done_cycle", 32'(first_done()), 32'd65);
        chk("s1_busy_at_66", 32'(busy66), 32'd0);
        chk("s1_block_idx_at_20", 32'(blk_at20), 32'd1);
        chk("s1_EN_W_count", 32'(n_w), 32'd4);
        chk("s1_EN_I_count", 32'(n_i), 32'd28);
        chk("s1_EN_O_In_count", 32'(n_oi), 32'd16);
        chk("s1_EN_O_Out_count", 32'(n_oo), 32'd16);
        $display("[TB] pass clean: done at cycle %0d, EN counts %0d/%0d/%0d/%0d",
                 first_done(), n_w, n_i, n_oi, n_oo);

        // Scenario 2: 3-cycle stall in the middle of LOAD_I.
        reset_dut();
        for (int c = 0; c < 75; c++) begin
            bus.start = (cyc == 0); bus.stall = (cyc >= 8 && cyc <= 10);
            cycle();
        end
        bus.stall = 1'b0;
        chk("s2_done_cycle", 32'(first_done()), 32'd68);
        chk("s2_EN_I_block0", 32'(n_i_blk0), 32'd7);
        chk("s2_EN_I_count", 32'(n_i), 32'd28);
        $display("[TB] pass stalled: done at cycle %0d, block0 EN_I %0d", first_done(), n_i_blk0);

        // Scenario 3: reset during block 1 ACCUM, then a fresh pass.
        reset_dut();
        for (int c = 0; c < 105; c++) begin
            bus.start = (cyc == 0 || cyc == 33); bus.stall = 1'b0;
            sclr = (cyc == 30);
            cycle();
        end
        sclr = 1'b0;
        chk("s3_done_count", 32'(done_cycles.size()), 32'd1);
        chk("s3_done_cycle", 32'(first_done()), 32'd98);
        $display("[TB] pass aborted+restarted: done at cycle %0d", first_done());

        // Scenario 4: start pulses while busy are ignored.
        reset_dut();
        for (int c = 0; c < 72; c++) begin
            bus.start = (cyc == 0 || cyc == 10 || cyc == 40); bus.stall = 1'b0;
            cycle();
        end
        chk("s4_done_count", 32'(done_cycles.size()), 32'd1);
        chk("s4_done_cycle", 32'(first_done()), 32'd65);
        $display("[TB] pass with stray starts: done at cycle %0d", first_done());

        // Scenario 5: start held high, back-to-back passes.
        reset_dut();
        for (int c = 0; c < 140; c++) begin
            bus.start = 1'b1; bus.stall = 1'b0;
            cycle();
        end
        bus.start = 1'b0;
        chk("s5_done_count", 32'(done_cycles.size()), 32'd2);
        chk("s5_done_first", 32'(first_done()), 32'd65);
        chk("s5_done_second", 32'((done_cycles.size() > 1) ? done_cycles[1] : -1), 32'd131);
        chk("s5_idle_at_66", 32'(busy66), 32'd0);
        $display("[TB] held start: %0d done pulses", done_cycles.size());

        // Scenario 6: random start/stall with occasional reset.
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.stall = ($urandom_range(0, 4) == 0);
            sclr      = ($urandom_range(0, 149) == 0);
            cycle();
        end
        sclr = 1'b0; bus.start = 1'b0; bus.stall = 1'b0;
        $display("[TB] random run: %0d done pulses, %0d EN_I cycles", done_cycles.size(), n_i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
